// File: rtl/led_matrix_scanner_pkg.sv
// Shared types and constants for the multi-panel LED matrix scan engine.
// Holds the scan FSM encoding and the all-off row pattern.
package led_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BLANK = 2'd1,
        S_DRIVE = 2'd2
    } scan_state_t;

    localparam int ROW_MAX = 64;
    localparam logic [ROW_MAX-1:0] ROW_OFF = '1;

endpackage

// File: rtl/led_matrix_scanner_if.sv
// Frame-store write port and bank-swap handshake of the LED scanner.
// The master writes columns and requests swaps; the scanner acknowledges.
interface led_matrix_scanner_if #(
    parameter int NUM_PANELS = 2,
    parameter int ROWS       = 8,
    parameter int COLS       = 8
);
    localparam int PW = (NUM_PANELS > 1) ? $clog2(NUM_PANELS) : 1;
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;

    logic            wr_en;
    logic [PW-1:0]   wr_panel;
    logic [CW-1:0]   wr_col;
    logic [ROWS-1:0] wr_data;
    logic            swap_req;
    logic            swap_ack;

    modport master (
        output wr_en, wr_panel, wr_col, wr_data, swap_req,
        input  swap_ack
    );

    modport slave (
        input  wr_en, wr_panel, wr_col, wr_data, swap_req,
        output swap_ack
    );

endinterface

// File: rtl/led_matrix_scanner_frame_buffer.sv
// Double-buffered pixel store: writes go to the back bank, reads come
// from the front bank, and a swap exchanges the two without copying.
module led_frame_buffer #(
    parameter int NUM_PANELS = 2,
    parameter int ROWS       = 8,
    parameter int COLS       = 8,
    localparam int PW = (NUM_PANELS > 1) ? $clog2(NUM_PANELS) : 1,
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            swap,
    input  logic            wr_en,
    input  logic [PW-1:0]   wr_panel,
    input  logic [CW-1:0]   wr_col,
    input  logic [ROWS-1:0] wr_data,
    input  logic [PW-1:0]   rd_panel,
    input  logic [CW-1:0]   rd_col,
    output logic [ROWS-1:0] rd_data
);

    logic            front_q, front_d;
    logic            wr_ok;
    logic [ROWS-1:0] mem_q [2][NUM_PANELS][COLS];
    logic [ROWS-1:0] mem_d [2][NUM_PANELS][COLS];

    // Write targets the pre-swap back bank, so a same-cycle swap shows it.
    always_comb begin
        wr_ok = wr_en
            && (int'(wr_panel) < NUM_PANELS)
            && (int'(wr_col) < COLS);
        mem_d = mem_q;
        if (wr_ok) begin
            mem_d[~front_q][wr_panel][wr_col] = wr_data;
        end
        front_d = front_q ^ swap;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            front_q <= 1'b0;
            for (int b = 0; b < 2; b++) begin
                for (int p = 0; p < NUM_PANELS; p++) begin
                    for (int c = 0; c < COLS; c++) begin
                        mem_q[b][p][c] <= '0;
                    end
                end
            end
        end else begin
            front_q <= front_d;
            mem_q   <= mem_d;
        end
    end

    assign rd_data = mem_q[front_q][rd_panel][rd_col];

endmodule

// File: rtl/led_matrix_scanner.sv
// Column-multiplexed scan engine for several LED panels on a shared row bus,
// with PWM brightness, anti-ghost blanking and double-buffered frames.
module led_matrix_scanner
    import led_pkg::*;
#(
    parameter int NUM_PANELS = 2,
    parameter int ROWS       = 8,
    parameter int COLS       = 8,
    parameter int SLOT_LOG2  = 14,
    parameter int BLANK_CYC  = 64,
    parameter int BRIGHT_W   = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enable,
    input  logic [BRIGHT_W-1:0]        brightness,
    led_matrix_scanner_if.slave        bus,
    output logic                       frame_start,
    output logic [ROWS-1:0]            row_n,
    output logic [NUM_PANELS*COLS-1:0] col
);

    localparam int PW   = (NUM_PANELS > 1) ? $clog2(NUM_PANELS) : 1;
    localparam int CW   = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int NCOL = NUM_PANELS * COLS;

    localparam logic [SLOT_LOG2-1:0] CYC_LAST   = '1;
    localparam logic [SLOT_LOG2-1:0] BLANK_LAST = SLOT_LOG2'(BLANK_CYC - 1);
    localparam logic [PW-1:0]        PAN_LAST   = PW'(NUM_PANELS - 1);
    localparam logic [CW-1:0]        COL_LAST   = CW'(COLS - 1);

    scan_state_t          state_q, state_d;
    logic [SLOT_LOG2-1:0] cyc_q, cyc_d;
    logic [PW-1:0]        pan_q, pan_d;
    logic [CW-1:0]        cix_q, cix_d;
    logic                 pend_q, pend_d;
    logic                 ack_q, ack_d;
    logic                 fs_q, fs_d;
    logic [ROWS-1:0]      row_q, row_d;
    logic [NCOL-1:0]      col_q, col_d;

    logic                 slot_end, frame_end;
    logic                 want, swap, lit;
    logic [ROWS-1:0]      pix;

    led_frame_buffer #(
        .NUM_PANELS (NUM_PANELS),
        .ROWS       (ROWS),
        .COLS       (COLS)
    ) u_fb (
        .clk      (clk),
        .rst_n    (reset),
        .swap     (swap),
        .wr_en    (bus.wr_en),
        .wr_panel (bus.wr_panel),
        .wr_col   (bus.wr_col),
        .wr_data  (bus.wr_data),
        .rd_panel (pan_q),
        .rd_col   (cix_q),
        .rd_data  (pix)
    );

    always_comb begin
        state_d   = state_q;
        cyc_d     = cyc_q;
        pan_d     = pan_q;
        cix_d     = cix_q;
        slot_end  = (state_q == S_DRIVE) && (cyc_q == CYC_LAST);
        frame_end = slot_end && (pan_q == PAN_LAST) && (cix_q == COL_LAST);
        if (!enable) begin
            state_d = S_IDLE;
            cyc_d   = '0;
            pan_d   = '0;
            cix_d   = '0;
        end else begin
            unique case (state_q)
                S_IDLE: state_d = S_BLANK;
                S_BLANK: begin
                    cyc_d = cyc_q + 1'b1;
                    if (cyc_q == BLANK_LAST) state_d = S_DRIVE;
                end
                S_DRIVE: begin
                    cyc_d = cyc_q + 1'b1;
                    if (slot_end) begin
                        state_d = S_BLANK;
                        if (pan_q == PAN_LAST) begin
                            pan_d = '0;
                            cix_d = (cix_q == COL_LAST) ? '0 : cix_q + 1'b1;
                        end else begin
                            pan_d = pan_q + 1'b1;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Requests merge into one pending swap, taken at frame end or when parked.
    always_comb begin
        want   = pend_q | bus.swap_req;
        swap   = want && ((state_q == S_IDLE) || frame_end);
        pend_d = want && !swap;
        ack_d  = swap;
    end

    always_comb begin
        lit = enable
            && (state_q == S_DRIVE)
            && (cyc_q[SLOT_LOG2-1 -: BRIGHT_W] < brightness);
        fs_d = enable
            && (state_q == S_BLANK)
            && (cyc_q == '0)
            && (pan_q == '0)
            && (cix_q == '0);
        row_d = lit ? ~pix : ROW_OFF[ROWS-1:0];
        col_d = lit ? (NCOL'(1) << (int'(pan_q) * COLS + int'(cix_q))) : '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cyc_q   <= '0;
            pan_q   <= '0;
            cix_q   <= '0;
            pend_q  <= 1'b0;
            ack_q   <= 1'b0;
            fs_q    <= 1'b0;
            row_q   <= ROW_OFF[ROWS-1:0];
            col_q   <= '0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            pan_q   <= pan_d;
            cix_q   <= cix_d;
            pend_q  <= pend_d;
            ack_q   <= ack_d;
            fs_q    <= fs_d;
            row_q   <= row_d;
            col_q   <= col_d;
        end
    end

    assign bus.swap_ack = ack_q;
    assign frame_start  = fs_q;
    assign row_n        = row_q;
    assign col          = col_q;

endmodule

// File: tb/tb_led_matrix_scanner.sv
// Self-checking bench for led_matrix_scanner using a short scan slot.
// A frame-position model predicts every output cycle against a scoreboard.
module tb_led_matrix_scanner;

    localparam int NP    = 2;
    localparam int RW    = 8;
    localparam int CL    = 8;
    localparam int SL    = 6;
    localparam int BC    = 4;
    localparam int BW    = 4;
    localparam int SLOT  = 1 << SL;
    localparam int FRAME = SLOT * NP * CL;

    typedef struct packed {
        logic [NP*CL-1:0] col;
        logic [RW-1:0]    row_n;
        logic             ack;
        logic             fs;
    } obs_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             enable = 1'b0;
    logic [BW-1:0]    brightness = '0;
    logic             frame_start;
    logic [RW-1:0]    row_n;
    logic [NP*CL-1:0] col;

    int   checks = 0;
    int   failures = 0;
    int   acks = 0;
    logic ref_front = 1'b0;
    logic [RW-1:0] ref_bank [2][NP][CL];
    obs_t sb_q [$];

    led_matrix_scanner_if #(.NUM_PANELS(NP), .ROWS(RW), .COLS(CL)) bus ();

    led_matrix_scanner #(
        .NUM_PANELS (NP),
        .ROWS       (RW),
        .COLS       (CL),
        .SLOT_LOG2  (SL),
        .BLANK_CYC  (BC),
        .BRIGHT_W   (BW)
    ) dut (
        .clk         (clk),
        .reset       (rst_n),
        .enable      (enable),
        .brightness  (brightness),
        .bus         (bus),
        .frame_start (frame_start),
        .row_n       (row_n),
        .col         (col)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        if (bus.swap_ack === 1'b1) begin
            ref_front = ~ref_front;
            acks++;
        end
    endtask

    // k counts cycles since frame_start was observed.
    function automatic obs_t expect_at(int k, int ack_k, int br);
        obs_t e;
        int s, c, p, cc;
        s = (k / SLOT) % (NP * CL);
        c = k % SLOT;
        p = s % NP;
        cc = s / NP;
        e.col = '0;
        e.row_n = 8'hFF;
        e.ack = (k == ack_k);
        e.fs = (k % FRAME == 0);
        if (c >= BC && (c >> (SL - BW)) < br) begin
            e.col = (NP*CL)'(1) << (p * CL + cc);
            e.row_n = ~ref_bank[ref_front][1'(p)][3'(cc)];
        end
        return e;
    endfunction

    task automatic scan_check(input int k0, input int k1, input int ack_k);
        for (int k = k0; k <= k1; k++) begin
            obs_t got, e;
            sb_q.push_back(expect_at(k, ack_k, int'(brightness)));
            got = {col, row_n, bus.swap_ack, frame_start};
            e = sb_q.pop_front();
            checks++;
            if (got !== e) begin
                failures++;
                $display("FAIL scan k=%0d got col=%h row_n=%h ack=%b fs=%b want col=%h row_n=%h ack=%b fs=%b",
                         k, got.col, got.row_n, got.ack, got.fs,
                         e.col, e.row_n, e.ack, e.fs);
            end
            if (k != k1) tick();
        end
    endtask

    task automatic wait_fs(input int budget, output int n);
        n = 0;
        while (frame_start !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (frame_start !== 1'b1) begin
            failures++;
            $display("FAIL frame_start_timeout got=%b want=1", frame_start);
        end
    endtask

    task automatic wr(input logic [0:0] p, input logic [2:0] c, input logic [7:0] d);
        bus.wr_en = 1'b1;
        bus.wr_panel = p;
        bus.wr_col = c;
        bus.wr_data = d;
        ref_bank[~ref_front][p][c] = d;
        tick();
        bus.wr_en = 1'b0;
    endtask

    task automatic pulse_swap();
        bus.swap_req = 1'b1;
        tick();
        bus.swap_req = 1'b0;
    endtask

    task automatic test_reset();
        int n;
        repeat (3) tick();
        checks += 4;
        if (row_n !== 8'hFF) begin
            failures++; $display("FAIL reset_row_n got=%h want=ff", row_n);
        end
        if (col !== 16'h0) begin
            failures++; $display("FAIL reset_col got=%h want=0000", col);
        end
        if (bus.swap_ack !== 1'b0) begin
            failures++; $display("FAIL reset_ack got=%b want=0", bus.swap_ack);
        end
        if (frame_start !== 1'b0) begin
            failures++; $display("FAIL reset_fs got=%b want=0", frame_start);
        end
        rst_n = 1'b1;
        enable = 1'b1;
        brightness = 4'd15;
        wait_fs(10, n);
        checks++;
        if (n != 2) begin
            failures++; $display("FAIL fs_latency got=%0d want=2", n);
        end
        scan_check(0, 10, -1);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (row_n !== 8'hFF || col !== 16'h0) begin
            failures++;
            $display("FAIL async_reset got row_n=%h col=%h want ff 0000", row_n, col);
        end
        #2 rst_n = 1'b1;
        ref_front = 1'b0;
        wait_fs(10, n);
        checks++;
        if (n != 2) begin
            failures++; $display("FAIL fs_after_reset got=%0d want=2", n);
        end
    endtask

    task automatic test_pixel();
        wr(1'b0, 3'd3, 8'h81);
        pulse_swap();
        scan_check(2, FRAME - 1, FRAME - 1);
        tick();
        scan_check(0, 6 * SLOT + 10, -1);
        checks++;
        if (col !== 16'h0008 || row_n !== 8'h7E) begin
            failures++;
            $display("FAIL pixel_c3p0 got col=%h row_n=%h want 0008 7e", col, row_n);
        end
        scan_check(6 * SLOT + 10, FRAME - 1, -1);
        tick();
    endtask

    task automatic test_pwm();
        brightness = 4'd8;
        scan_check(0, FRAME - 1, -1);
        tick();
        brightness = 4'd0;
        scan_check(0, FRAME - 1, -1);
        tick();
        brightness = 4'd15;
    endtask

    task automatic test_merge();
        int a0;
        scan_check(0, 99, -1);
        wr(1'b1, 3'd5, 8'h3C);
        pulse_swap();
        scan_check(101, 150, -1);
        pulse_swap();
        a0 = acks;
        scan_check(151, FRAME - 1, FRAME - 1);
        tick();
        checks++;
        if (acks != a0 + 1) begin
            failures++; $display("FAIL merge_acks got=%0d want=%0d", acks - a0, 1);
        end
        scan_check(0, FRAME - 1, -1);
        tick();
    endtask

    task automatic test_write_swap();
        scan_check(0, FRAME - 2, -1);
        bus.wr_en = 1'b1;
        bus.wr_panel = 1'b0;
        bus.wr_col = 3'd7;
        bus.wr_data = 8'hA5;
        ref_bank[~ref_front][0][7] = 8'hA5;
        bus.swap_req = 1'b1;
        tick();
        bus.wr_en = 1'b0;
        bus.swap_req = 1'b0;
        scan_check(FRAME - 1, FRAME - 1, FRAME - 1);
        tick();
        scan_check(0, FRAME - 1, -1);
        tick();
    endtask

    task automatic test_enable_drop();
        int n;
        scan_check(0, 5 * SLOT + 40, -1);
        enable = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (row_n !== 8'hFF || col !== 16'h0 || frame_start !== 1'b0) begin
                failures++;
                $display("FAIL disabled_blank i=%0d got row_n=%h col=%h fs=%b want ff 0000 0",
                         i, row_n, col, frame_start);
            end
        end
        enable = 1'b1;
        wait_fs(10, n);
        checks++;
        if (n != 2) begin
            failures++; $display("FAIL reenable_fs got=%0d want=2", n);
        end
        scan_check(0, 100, -1);
    endtask

    initial begin
        bus.wr_en = 1'b0;
        bus.wr_panel = '0;
        bus.wr_col = '0;
        bus.wr_data = '0;
        bus.swap_req = 1'b0;
        for (int b = 0; b < 2; b++)
            for (int p = 0; p < NP; p++)
                for (int c = 0; c < CL; c++)
                    ref_bank[b][p][c] = '0;
        test_reset();
        test_pixel();
        test_pwm();
        test_merge();
        test_write_swap();
        test_enable_drop();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
